pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard and forwarding controller for the second-generation five-stage pipelined CPU. It keeps its own shadow copy of writer information for the EX, MEM and WB stages and drives the control signals for the pipeline registers: PC write enable, IF/ID hold and flush, ID/EX bubble and flush, and EX/MEM flush. It also produces forwarding selects for both EX operands and keeps saturating stall and flush counters. It sits beside the datapath and replaces the first generation's flush-only branch handling (no forwarding, no stalls).

## Interface
Parameters:
- ADDR_W, 5, register address width.
- FLUSH_DEPTH, 3, number of younger stages flushed on a taken branch. 3 means branch resolved in MEM (flush IF/ID, ID/EX, EX/MEM); 2 means resolved in EX (flush IF/ID, ID/EX).
- CNT_W, 16, width of each performance counter.

Ports:
- clk_i, in, 1, clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- id_valid_i, in, 1, ID stage holds a real instruction.
- id_rs_i / id_rt_i, in, ADDR_W each, ID source register addresses.
- id_use_rs_i / id_use_rt_i, in, 1 each, the instruction reads that source.
- id_dst_i, in, ADDR_W, ID destination (already RT/RD-muxed).
- id_reg_write_i / id_mem_read_i, in, 1 each, ID writes a register / is a load.
- branch_taken_i, in, 1, taken branch resolved in the stage set by FLUSH_DEPTH.
- freeze_i, in, 1, global stall (memory wait); the whole pipeline holds.
- pc_write_o, out, 1, PC may update.
- if_id_write_o, out, 1, IF/ID may load.
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, out, 1 each, clear the register to a bubble.
- id_ex_bubble_o, out, 1, load a bubble into ID/EX (load-use stall).
- fwd_a_o / fwd_b_o, out, 2 each, EX operand select: 00 register file, 01 MEM ALU result, 10 WB write data.
- stall_cnt_o / flush_cnt_o, out, CNT_W each, counters.

## Operation
- Shadow state:
  - EX entry: valid, rs, rt, use_rs, use_rt, dst, reg_write, mem_read.
  - MEM and WB entries: valid, dst, reg_write.
- Advance (no freeze, no stall, no flush): ID inputs go to EX (valid = id_valid_i), EX goes to MEM, MEM goes to WB.
- A writer is "live" when valid, reg_write, and dst != 0. Register $0 is never forwarded and never causes a stall.
- Forwarding (per operand, using EX rs for A and EX rt for B, only when that operand is used):
  - MEM live and dst match gives 01.
  - Else WB live and dst match gives 10.
  - Else 00. MEM has priority over WB.
- Load-use hazard: EX live, EX mem_read, and EX dst matches id_rs_i (with id_use_rs_i) or id_rt_i (with id_use_rt_i), with id_valid_i set. Response:
  - pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1.
  - The EX entry becomes invalid on the next edge; MEM and WB advance normally.
- Taken branch:
  - FLUSH_DEPTH=3: if_id/id_ex/ex_mem flush outputs = 1; next-edge EX and MEM entries are invalid; WB takes the old MEM entry.
  - FLUSH_DEPTH=2: if_id/id_ex flush = 1, ex_mem_flush_o = 0; EX entry invalid; MEM takes the old EX entry.
  - pc_write_o=1 in both cases, so the branch target is loaded.
- Priority: reset > freeze > flush > load-use stall.
  - Freeze: pc_write_o=0, if_id_write_o=0, all flush and bubble outputs 0, shadow state and counters hold.
  - Flush with a simultaneous load-use: the stall is suppressed and not counted.
- Counters:
  - stall_cnt_o increments by 1 on each edge where a load-use stall takes effect.
  - flush_cnt_o increments by 1 on each edge where a taken-branch flush takes effect.
  - Both saturate at 2^CNT_W-1.

## Timing
- Reset (asynchronous, on rst_n=0):
  - All shadow valid bits = 0; counters = 0.
  - Outputs: pc_write_o=1, if_id_write_o=1, flush and bubble outputs = 0, fwd = 00.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- All control and forward outputs are combinational from the current inputs and registered shadow state, valid in the same cycle. Zero added latency.
- Counters are registered: they reflect an event one edge after it.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MEM (not forwardable as a load) and reaches WB a cycle later. The consumer in EX then sees fwd=10.
- freeze_i held for N cycles delays every transition by exactly N cycles. A branch_taken_i held across the freeze flushes once, on the first unfrozen edge.

## Test plan
- Back-to-back dependency: add $3,$1,$2 then sub $4,$3,$5 gives fwd_a_o=01 while sub is in EX. With one independent instruction between them, fwd_a_o=10. With two between, 00.
- Load-use: lw $2,0($1) then add $4,$2,$2 gives one cycle of pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, and stall_cnt_o goes 0→1. When add is in EX, fwd_a_o=fwd_b_o=10.
- $0 destination: addi $0,$0,5 then add $1,$0,$0, and lw $0 then a user: fwd stays 00, no stall.
- Branch collision: branch_taken_i=1 in the same cycle as an ID load-use. Flush outputs 1 (per FLUSH_DEPTH 3 and 2), id_ex_bubble_o=0, flush_cnt_o+1, stall_cnt_o unchanged.
- Freeze and reset:
  - freeze_i=1 for 3 cycles during a pending load-use: outputs frozen, counters unchanged; the stall occurs on the first unfrozen cycle.
  - rst_n pulsed low mid-stream: every output returns to its reset value asynchronously.
- Saturation: CNT_W=4 with 20 load-use stalls gives stall_cnt_o=15.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: load-use stalls, taken-branch flushes, EX operand forwarding, perf counters.
// Control and forward outputs are combinational (zero latency), counters lag one edge; freeze_i holds all state.
module pipe_hazard_unit #(
  parameter int ADDR_W      = 5,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [ADDR_W-1:0] id_dst_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              branch_taken_i,
  input  logic              freeze_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_flush_o,
  output logic              id_ex_bubble_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              use_rs;
    logic              use_rt;
    logic [ADDR_W-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } ex_ent_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] dst;
    logic              reg_write;
  } wr_ent_t;

  // Branch resolved in MEM means the instruction already sitting in EX/MEM is wrong-path too.
  localparam bit FLUSH_EX_MEM = (FLUSH_DEPTH >= 3);

  ex_ent_t          r_ex;
  wr_ent_t          r_mem;
  wr_ent_t          r_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  ex_ent_t w_id_ent;
  wr_ent_t w_ex_wr;
  logic    w_ex_live;
  logic    w_mem_live;
  logic    w_wb_live;
  logic    w_rs_hit;
  logic    w_rt_hit;
  logic    w_load_use;
  logic    w_run;
  logic    w_flush;
  logic    w_stall;
  logic    w_a_mem;
  logic    w_a_wb;
  logic    w_b_mem;
  logic    w_b_wb;

  assign w_id_ent = '{vld: id_valid_i, rs: id_rs_i, rt: id_rt_i, use_rs: id_use_rs_i,
                      use_rt: id_use_rt_i, dst: id_dst_i, reg_write: id_reg_write_i,
                      mem_read: id_mem_read_i};
  assign w_ex_wr  = '{vld: r_ex.vld, dst: r_ex.dst, reg_write: r_ex.reg_write};

  // A writer to $0 is never live, so $0 can neither forward nor stall.
  assign w_ex_live  = r_ex.vld  & r_ex.reg_write  & (|r_ex.dst);
  assign w_mem_live = r_mem.vld & r_mem.reg_write & (|r_mem.dst);
  assign w_wb_live  = r_wb.vld  & r_wb.reg_write  & (|r_wb.dst);

  assign w_rs_hit   = id_use_rs_i & (id_rs_i == r_ex.dst);
  assign w_rt_hit   = id_use_rt_i & (id_rt_i == r_ex.dst);
  assign w_load_use = id_valid_i & w_ex_live & r_ex.mem_read & (w_rs_hit | w_rt_hit);

  assign w_run   = rst_n & ~freeze_i;
  assign w_flush = w_run & branch_taken_i;
  assign w_stall = w_run & ~branch_taken_i & w_load_use;

  assign pc_write_o     = ~rst_n | (~freeze_i & ~w_stall);
  assign if_id_write_o  = ~rst_n | (~freeze_i & ~w_stall);
  assign if_id_flush_o  = w_flush;
  assign id_ex_flush_o  = w_flush;
  assign ex_mem_flush_o = w_flush & FLUSH_EX_MEM;
  assign id_ex_bubble_o = w_stall;

  assign w_a_mem = r_ex.vld & r_ex.use_rs & w_mem_live & (r_mem.dst == r_ex.rs);
  assign w_a_wb  = r_ex.vld & r_ex.use_rs & w_wb_live  & (r_wb.dst  == r_ex.rs);
  assign w_b_mem = r_ex.vld & r_ex.use_rt & w_mem_live & (r_mem.dst == r_ex.rt);
  assign w_b_wb  = r_ex.vld & r_ex.use_rt & w_wb_live  & (r_wb.dst  == r_ex.rt);

  assign fwd_a_o = w_a_mem ? 2'b01 : (w_a_wb ? 2'b10 : 2'b00);
  assign fwd_b_o = w_b_mem ? 2'b01 : (w_b_wb ? 2'b10 : 2'b00);

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!freeze_i) begin
      r_wb <= r_mem;
      if (w_flush) begin
        r_ex  <= '0;
        r_mem <= FLUSH_EX_MEM ? '0 : w_ex_wr;
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_stall) begin
        r_ex  <= '0;
        r_mem <= w_ex_wr;
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_ex  <= w_id_ent;
        r_mem <= w_ex_wr;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three instances (default, FLUSH_DEPTH=2, CNT_W=4) share stimulus,
// each checked every cycle against an instruction-level pipeline model, plus literal spot checks.
module tb_pipe_hazard_unit;

  typedef struct packed {
    logic       vld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } ins_t;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  ins_t cur   = '0;
  logic br    = 1'b0;
  logic frz   = 1'b0;

  logic [2:0]  pc_w, ifid_w, ifid_f, idex_f, exmem_f, bub;
  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  int nchk = 0;
  int nerr = 0;

  ins_t m_ex [3];
  ins_t m_mem[3];
  ins_t m_wb [3];
  int   m_sc [3];
  int   m_fc [3];
  int   fd   [3] = '{3, 2, 3};
  int   cmax [3] = '{65535, 65535, 15};

  always #5 clk_i = ~clk_i;

  pipe_hazard_unit u_dut0 (
    .clk_i(clk_i), .rst_n(rst_n), .id_valid_i(cur.vld), .id_rs_i(cur.rs), .id_rt_i(cur.rt),
    .id_use_rs_i(cur.urs), .id_use_rt_i(cur.urt), .id_dst_i(cur.dst), .id_reg_write_i(cur.rw),
    .id_mem_read_i(cur.mr), .branch_taken_i(br), .freeze_i(frz),
    .pc_write_o(pc_w[0]), .if_id_write_o(ifid_w[0]), .if_id_flush_o(ifid_f[0]),
    .id_ex_flush_o(idex_f[0]), .ex_mem_flush_o(exmem_f[0]), .id_ex_bubble_o(bub[0]),
    .fwd_a_o(fa[0]), .fwd_b_o(fb[0]), .stall_cnt_o(sc0), .flush_cnt_o(fc0));

  pipe_hazard_unit #(.FLUSH_DEPTH(2)) u_dut1 (
    .clk_i(clk_i), .rst_n(rst_n), .id_valid_i(cur.vld), .id_rs_i(cur.rs), .id_rt_i(cur.rt),
    .id_use_rs_i(cur.urs), .id_use_rt_i(cur.urt), .id_dst_i(cur.dst), .id_reg_write_i(cur.rw),
    .id_mem_read_i(cur.mr), .branch_taken_i(br), .freeze_i(frz),
    .pc_write_o(pc_w[1]), .if_id_write_o(ifid_w[1]), .if_id_flush_o(ifid_f[1]),
    .id_ex_flush_o(idex_f[1]), .ex_mem_flush_o(exmem_f[1]), .id_ex_bubble_o(bub[1]),
    .fwd_a_o(fa[1]), .fwd_b_o(fb[1]), .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  pipe_hazard_unit #(.CNT_W(4)) u_dut2 (
    .clk_i(clk_i), .rst_n(rst_n), .id_valid_i(cur.vld), .id_rs_i(cur.rs), .id_rt_i(cur.rt),
    .id_use_rs_i(cur.urs), .id_use_rt_i(cur.urt), .id_dst_i(cur.dst), .id_reg_write_i(cur.rw),
    .id_mem_read_i(cur.mr), .branch_taken_i(br), .freeze_i(frz),
    .pc_write_o(pc_w[2]), .if_id_write_o(ifid_w[2]), .if_id_flush_o(ifid_f[2]),
    .id_ex_flush_o(idex_f[2]), .ex_mem_flush_o(exmem_f[2]), .id_ex_bubble_o(bub[2]),
    .fwd_a_o(fa[2]), .fwd_b_o(fb[2]), .stall_cnt_o(sc2), .flush_cnt_o(fc2));

  function automatic int get_sc(int i);
    return (i == 0) ? int'(sc0) : (i == 1) ? int'(sc1) : int'(sc2);
  endfunction

  function automatic int get_fc(int i);
    return (i == 0) ? int'(fc0) : (i == 1) ? int'(fc1) : int'(fc2);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(bit vld, int dst, int rs, bit urs, int rt, bit urt, bit rw, bit mr);
    ins_t x;
    x.vld = vld; x.dst = 5'(dst); x.rs = 5'(rs); x.urs = urs;
    x.rt = 5'(rt); x.urt = urt; x.rw = rw; x.mr = mr;
    return x;
  endfunction

  function automatic ins_t alu(int d, int s, int t);
    return mk(1, d, s, 1, t, 1, 1, 0);
  endfunction

  function automatic ins_t addi(int d, int s);
    return mk(1, d, s, 1, 0, 0, 1, 0);
  endfunction

  function automatic ins_t lw(int d, int base);
    return mk(1, d, base, 1, 0, 0, 1, 1);
  endfunction

  function automatic bit live(ins_t x);
    return x.vld && x.rw && (x.dst != 0);
  endfunction

  // Which pipeline stage, if any, holds the newest value of src for the instruction in EX.
  function automatic int fwd_exp(int i, bit use_src, logic [4:0] src);
    if (!m_ex[i].vld || !use_src) return 0;
    if (live(m_mem[i]) && m_mem[i].dst == src) return 1;
    if (live(m_wb[i]) && m_wb[i].dst == src) return 2;
    return 0;
  endfunction

  function automatic bit lu_exp(int i);
    return cur.vld && live(m_ex[i]) && m_ex[i].mr &&
           ((cur.urs && cur.rs == m_ex[i].dst) || (cur.urt && cur.rt == m_ex[i].dst));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 3; i++) begin
      bit stall, fl;
      stall = !frz && !br && lu_exp(i);
      fl    = !frz && br;
      chk($sformatf("pc_write[%0d]", i), int'(pc_w[i]), int'(!frz && !stall));
      chk($sformatf("if_id_write[%0d]", i), int'(ifid_w[i]), int'(!frz && !stall));
      chk($sformatf("if_id_flush[%0d]", i), int'(ifid_f[i]), int'(fl));
      chk($sformatf("id_ex_flush[%0d]", i), int'(idex_f[i]), int'(fl));
      chk($sformatf("ex_mem_flush[%0d]", i), int'(exmem_f[i]), int'(fl && fd[i] == 3));
      chk($sformatf("bubble[%0d]", i), int'(bub[i]), int'(stall));
      chk($sformatf("fwd_a[%0d]", i), int'(fa[i]), fwd_exp(i, m_ex[i].urs, m_ex[i].rs));
      chk($sformatf("fwd_b[%0d]", i), int'(fb[i]), fwd_exp(i, m_ex[i].urt, m_ex[i].rt));
      chk($sformatf("stall_cnt[%0d]", i), get_sc(i), m_sc[i]);
      chk($sformatf("flush_cnt[%0d]", i), get_fc(i), m_fc[i]);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit lu;
      lu = lu_exp(i);
      if (!frz) begin
        m_wb[i] = m_mem[i];
        if (br) begin
          m_mem[i] = (fd[i] == 3) ? ins_t'(0) : m_ex[i];
          m_ex[i]  = '0;
          if (m_fc[i] < cmax[i]) m_fc[i]++;
        end else if (lu) begin
          m_mem[i] = m_ex[i];
          m_ex[i]  = '0;
          if (m_sc[i] < cmax[i]) m_sc[i]++;
        end else begin
          m_mem[i] = m_ex[i];
          m_ex[i]  = cur;
        end
      end
    end
  endtask

  task automatic drive(input ins_t x, input bit b, input bit f);
    @(posedge clk_i);
    #1;
    cur = x; br = b; frz = f;
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
    cmp_all();
    model_step();
  endtask

  task automatic cyc(input ins_t x, input bit b, input bit f);
    drive(x, b, f);
    settle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s pc_write[%0d]", tag, i), int'(pc_w[i]), 1);
      chk($sformatf("%s if_id_write[%0d]", tag, i), int'(ifid_w[i]), 1);
      chk($sformatf("%s flushes[%0d]", tag, i), int'({ifid_f[i], idex_f[i], exmem_f[i]}), 0);
      chk($sformatf("%s bubble[%0d]", tag, i), int'(bub[i]), 0);
      chk($sformatf("%s fwd[%0d]", tag, i), int'({fa[i], fb[i]}), 0);
      chk($sformatf("%s counters[%0d]", tag, i), get_sc(i) + get_fc(i), 0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    chk_reset_outputs("reset");
    #6 rst_n = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$5 -> MEM forward
    cyc(alu(3, 1, 2), 0, 0);
    cyc(alu(4, 3, 5), 0, 0);
    drive('0, 0, 0);
    chk("fwd_a back-to-back", int'(fa[0]), 1);
    settle();

    // one independent instruction between -> WB forward
    cyc(alu(3, 1, 2), 0, 0);
    cyc(alu(6, 7, 7), 0, 0);
    cyc(alu(4, 3, 5), 0, 0);
    drive('0, 0, 0);
    chk("fwd_a gap1", int'(fa[0]), 2);
    settle();

    // two between -> register file
    cyc(alu(3, 1, 2), 0, 0);
    cyc(alu(6, 7, 7), 0, 0);
    cyc(alu(8, 7, 7), 0, 0);
    cyc(alu(4, 3, 5), 0, 0);
    drive('0, 0, 0);
    chk("fwd_a gap2", int'(fa[0]), 0);
    settle();

    // lw $2,0($1) ; add $4,$2,$2 -> one stall, then WB forward on both operands
    cyc(lw(2, 1), 0, 0);
    drive(alu(4, 2, 2), 0, 0);
    chk("lu pc_write", int'(pc_w[0]), 0);
    chk("lu if_id_write", int'(ifid_w[0]), 0);
    chk("lu bubble", int'(bub[0]), 1);
    chk("lu stall_cnt before", int'(sc0), 0);
    settle();
    drive(alu(4, 2, 2), 0, 0);
    chk("lu bubble second cycle", int'(bub[0]), 0);
    chk("lu stall_cnt after", int'(sc0), 1);
    settle();
    drive('0, 0, 0);
    chk("lu fwd_a", int'(fa[0]), 2);
    chk("lu fwd_b", int'(fb[0]), 2);
    settle();

    // $0 as destination never forwards or stalls
    cyc(addi(0, 0), 0, 0);
    cyc(alu(1, 0, 0), 0, 0);
    drive('0, 0, 0);
    chk("zero fwd_a", int'(fa[0]), 0);
    chk("zero fwd_b", int'(fb[0]), 0);
    settle();
    cyc(lw(0, 1), 0, 0);
    drive(alu(5, 0, 0), 0, 0);
    chk("zero lw bubble", int'(bub[0]), 0);
    chk("zero lw pc_write", int'(pc_w[0]), 1);
    settle();

    // taken branch colliding with a load-use
    cyc(lw(2, 1), 0, 0);
    drive(alu(4, 2, 2), 1, 0);
    chk("br if_id_flush", int'(ifid_f[0]), 1);
    chk("br id_ex_flush", int'(idex_f[0]), 1);
    chk("br ex_mem_flush fd3", int'(exmem_f[0]), 1);
    chk("br ex_mem_flush fd2", int'(exmem_f[1]), 0);
    chk("br bubble fd3", int'(bub[0]), 0);
    chk("br bubble fd2", int'(bub[1]), 0);
    chk("br pc_write", int'(pc_w[0]), 1);
    settle();
    drive('0, 0, 0);
    chk("br flush_cnt", int'(fc0), 1);
    chk("br stall_cnt", int'(sc0), 1);
    settle();

    // freeze across a pending load-use
    cyc(lw(2, 1), 0, 0);
    repeat (3) begin
      drive(alu(4, 2, 2), 0, 1);
      chk("frz pc_write", int'(pc_w[0]), 0);
      chk("frz bubble", int'(bub[0]), 0);
      chk("frz stall_cnt", int'(sc0), 1);
      settle();
    end
    drive(alu(4, 2, 2), 0, 0);
    chk("frz release bubble", int'(bub[0]), 1);
    settle();
    drive(alu(4, 2, 2), 0, 0);
    chk("frz release stall_cnt", int'(sc0), 2);
    settle();

    // saturation on the CNT_W=4 instance
    repeat (20) begin
      cyc(lw(2, 1), 0, 0);
      cyc(alu(4, 2, 2), 0, 0);
      cyc(alu(4, 2, 2), 0, 0);
    end
    drive('0, 0, 0);
    chk("sat stall_cnt cnt4", int'(sc2), 15);
    chk("sat stall_cnt cnt16", int'(sc0), 22);
    settle();

    // asynchronous reset mid-stream, with branch and freeze still asserted
    cyc(lw(3, 1), 0, 0);
    drive(alu(4, 3, 3), 1, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async");
    model_reset();
    @(posedge clk_i);
    #2 rst_n = 1'b1;
    br = 1'b0; frz = 1'b0; cur = '0;

    repeat (3000) begin
      ins_t r;
      r.vld = ($urandom_range(0, 9) != 0);
      r.rs  = 5'($urandom_range(0, 3));
      r.rt  = 5'($urandom_range(0, 3));
      r.urs = 1'($urandom_range(0, 1));
      r.urt = 1'($urandom_range(0, 1));
      r.dst = 5'($urandom_range(0, 3));
      r.rw  = ($urandom_range(0, 4) != 0);
      r.mr  = ($urandom_range(0, 2) == 0);
      cyc(r, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
